mbm_share_arbiter: RTL and testbench



---
 rtl/mbm_share_pkg.sv | 18 +
 rtl/mbm_share_arbiter_mbm.sv | 42 ++++
 rtl/mbm_share_arbiter_rr_arb2.sv | 23 ++
 rtl/mbm_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mbm_share_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mbm_share_pkg.sv
// Package for the shared modified-Booth multiplier (MBM) arbiter.
// Contents: MBM operand/product widths, the arbiter FSM state type and
// the requester-id type.
package mbm_share_pkg;

    localparam int MBM_W  = 8;
    localparam int PROD_W = 2 * MBM_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_e;

    // 0 = ALU MUL path, 1 = address/index-scaling path
    typedef logic req_id_t;

endpackage

// File: rtl/mbm_share_arbiter_mbm.sv
// mbm: purely combinational signed 8x8 radix-4 modified-Booth multiplier.
// Ports:
//   x : multiplicand, two's complement
//   y : multiplier, two's complement
//   p : 16-bit signed product
module mbm
    import mbm_share_pkg::*;
(
    input  logic [MBM_W-1:0]  x,
    input  logic [MBM_W-1:0]  y,
    output logic [PROD_W-1:0] p
);

    logic [PROD_W-1:0] xs;
    logic [MBM_W:0]    y_ext;
    logic [PROD_W-1:0] pp;
    logic [PROD_W-1:0] acc;

    assign xs    = {{MBM_W{x[MBM_W-1]}}, x};
    assign y_ext = {y, 1'b0};

    // Each overlapping 3-bit window of y selects a digit in {-2..2};
    // the partial products are summed modulo 2^16, which is exact since
    // every 8x8 signed product fits in 16 bits.
    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < MBM_W / 2; i++) begin
            case (y_ext[2*i +: 3])
                3'b001, 3'b010: pp = xs;
                3'b011:         pp = xs << 1;
                3'b100:         pp = -(xs << 1);
                3'b101, 3'b110: pp = -xs;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * i));
        end
    end

    assign p = acc;

endmodule

// File: rtl/mbm_share_arbiter_rr_arb2.sv
// rr_arb2: combinational 2-way round-robin grant.
// Ports:
//   valid0, valid1 : requests
//   last_grant     : id granted most recently; the other side wins a tie
//   enable         : when low, no grant is issued
//   grant0, grant1 : one-hot or zero grant
module rr_arb2
    import mbm_share_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  req_id_t last_grant,
    input  logic    enable,
    output logic    grant0,
    output logic    grant1
);

    always_comb begin
        grant0 = enable & valid0 & (~valid1 | last_grant);
        grant1 = enable & valid1 & (~valid0 | ~last_grant);
    end

endmodule

// File: rtl/mbm_share_arbiter.sv
// mbm_share_arbiter: shares one combinational MBM between requester 0
// (ALU MUL) and requester 1 (address/index scaling). Round-robin grant,
// registered operands and products, per-requester result return with
// backpressure. Accept -> CALC -> HOLD, at least 3 cycles per op.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   reqN_valid/ready/x/y       operand handshake for requester N
//   resN_valid/ready/p         product handshake for requester N
//   busy                       high whenever the FSM is not IDLE
//   ops0_cnt, ops1_cnt         saturating completed-op counters, present
//                              only when MBM_SHARE_STATS_EN is defined
module mbm_share_arbiter
    import mbm_share_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    output logic           res0_valid,
    input  logic           res0_ready,
    output logic [2*W-1:0] res0_p,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic           res1_valid,
    input  logic           res1_ready,
    output logic [2*W-1:0] res1_p,
    output logic           busy
`ifdef MBM_SHARE_STATS_EN
    ,
    output logic [CNT_W-1:0] ops0_cnt,
    output logic [CNT_W-1:0] ops1_cnt
`endif
);

    if (W != MBM_W || CNT_W < 1) begin : g_bad_cfg
        $error("mbm_share_arbiter: W must be 8 and CNT_W must be positive");
    end

    state_e            state_q, state_d;
    req_id_t           owner_q, owner_d;
    req_id_t           last_grant_q, last_grant_d;
    logic [W-1:0]      op_x_q, op_x_d, op_y_q, op_y_d;
    logic [2*W-1:0]    res0_p_q, res0_p_d, res1_p_q, res1_p_d;
    logic              res0_valid_q, res0_valid_d, res1_valid_q, res1_valid_d;
    logic              grant0, grant1;
    logic              res_hs;
    logic [PROD_W-1:0] mbm_p;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .enable     (state_q == IDLE),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    mbm u_mbm (
        .x (op_x_q),
        .y (op_y_q),
        .p (mbm_p)
    );

    assign res_hs = owner_q ? (res1_valid_q & res1_ready) : (res0_valid_q & res0_ready);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        op_x_d       = op_x_q;
        op_y_d       = op_y_q;
        res0_p_d     = res0_p_q;
        res1_p_d     = res1_p_q;
        res0_valid_d = res0_valid_q;
        res1_valid_d = res1_valid_q;
        case (state_q)
            IDLE: begin
                // Grants already include valid, so any grant is an accept.
                if (grant0 | grant1) begin
                    op_x_d       = grant1 ? req1_x : req0_x;
                    op_y_d       = grant1 ? req1_y : req0_y;
                    owner_d      = grant1;
                    last_grant_d = grant1;
                    state_d      = CALC;
                end
            end
            CALC: begin
                // Only the owner's product register is written; the other
                // keeps whatever it last returned.
                if (owner_q) begin
                    res1_p_d     = mbm_p;
                    res1_valid_d = 1'b1;
                end else begin
                    res0_p_d     = mbm_p;
                    res0_valid_d = 1'b1;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (res_hs) begin
                    res0_valid_d = 1'b0;
                    res1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_x_q       <= '0;
            op_y_q       <= '0;
            res0_p_q     <= '0;
            res1_p_q     <= '0;
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_x_q       <= op_x_d;
            op_y_q       <= op_y_d;
            res0_p_q     <= res0_p_d;
            res1_p_q     <= res1_p_d;
            res0_valid_q <= res0_valid_d;
            res1_valid_q <= res1_valid_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign res0_valid = res0_valid_q;
    assign res1_valid = res1_valid_q;
    assign res0_p     = res0_p_q;
    assign res1_p     = res1_p_q;
    assign busy       = (state_q != IDLE);

`ifdef MBM_SHARE_STATS_EN
    logic [CNT_W-1:0] ops0_cnt_q, ops0_cnt_d, ops1_cnt_q, ops1_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        ops0_cnt_d = ops0_cnt_q;
        ops1_cnt_d = ops1_cnt_q;
        if (state_q == HOLD && res_hs) begin
            if (!owner_q && ops0_cnt_q != '1) ops0_cnt_d = ops0_cnt_q + CNT_W'(1);
            if (owner_q && ops1_cnt_q != '1)  ops1_cnt_d = ops1_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops0_cnt_q <= '0;
            ops1_cnt_q <= '0;
        end else begin
            ops0_cnt_q <= ops0_cnt_d;
            ops1_cnt_q <= ops1_cnt_d;
        end
    end

    assign ops0_cnt = ops0_cnt_q;
    assign ops1_cnt = ops1_cnt_q;
`else
    // No operation counters in this build.
`endif

endmodule

// File: tb/tb_mbm_share_arbiter.sv
// Self-checking bench for mbm_share_arbiter: directed literal cases plus a
// randomized phase, with a transaction-level reference model checked on
// every falling clock edge.
module tb_mbm_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        res0_valid, res1_valid;
    logic        res0_ready = 1'b1, res1_ready = 1'b1;
    logic [15:0] res0_p, res1_p;
    logic        busy;
`ifdef MBM_SHARE_STATS_EN
    logic [15:0] ops0_cnt, ops1_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mbm_share_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .res0_valid (res0_valid),
        .res0_ready (res0_ready),
        .res0_p     (res0_p),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .res1_valid (res1_valid),
        .res1_ready (res1_ready),
        .res1_p     (res1_p),
        .busy       (busy)
`ifdef MBM_SHARE_STATS_EN
        ,
        .ops0_cnt   (ops0_cnt),
        .ops1_cnt   (ops1_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // One op in flight at most; it becomes visible one cycle after accept
    // and retires on the owner's result handshake.
    bit          m_busy;
    bit          m_owner;
    bit          m_last;
    int          m_age;
    logic [15:0] m_prod;
    logic [15:0] m_p [2];
    int          m_cnt [2];

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        int ia, ib, r;
        ia = $signed(a);
        ib = $signed(b);
        r  = ia * ib;
        return r[15:0];
    endfunction

    always @(negedge clk) begin
        bit e_r0, e_r1;
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_last = 1; m_age = 0; m_prod = '0;
            m_p[0] = '0; m_p[1] = '0; m_cnt[0] = 0; m_cnt[1] = 0;
        end
        e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
        e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("res0_valid", res0_valid, m_busy && m_age >= 1 && !m_owner);
        chk("res1_valid", res1_valid, m_busy && m_age >= 1 && m_owner);
        chk("res0_p", res0_p, m_p[0]);
        chk("res1_p", res1_p, m_p[1]);
        chk("busy", busy, m_busy);
`ifdef MBM_SHARE_STATS_EN
        chk("ops0_cnt", ops0_cnt, m_cnt[0]);
        chk("ops1_cnt", ops1_cnt, m_cnt[1]);
`endif
        if (rst_n) begin
            if (m_busy) begin
                if (m_age == 0) begin
                    m_age = 1;
                    m_p[m_owner] = m_prod;
                end else if (m_owner ? res1_ready : res0_ready) begin
                    m_busy = 0;
                    if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
                end
            end else if (e_r0 || e_r1) begin
                m_busy  = 1;
                m_age   = 0;
                m_owner = e_r1;
                m_last  = e_r1;
                m_prod  = e_r1 ? smul(req1_x, req1_y) : smul(req0_x, req0_y);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic do_op(input bit id, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp, input string nm);
        bit ok = 0;
        res0_ready = 1; res1_ready = 1;
        if (id) begin req1_valid = 1; req1_x = x; req1_y = y; end
        else    begin req0_valid = 1; req0_x = x; req0_y = y; end
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk({nm, "_accept"}, ok, 1);
        tick();
        if (id) req1_valid = 0; else req0_valid = 0;
        chk({nm, "_calc_valid"}, {res0_valid, res1_valid}, 2'b00);
        tick();
        chk({nm, "_res_valid"}, {res0_valid, res1_valid}, id ? 2'b01 : 2'b10);
        chk({nm, "_res_p"}, id ? res1_p : res0_p, exp);
        tick();
        chk({nm, "_done"}, {res0_valid, res1_valid, busy}, 3'b000);
    endtask

    logic [7:0] ext [5] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h01};

    initial begin
        int g[$];
        int exp_g [4] = '{0, 1, 0, 1};
        logic [15:0] held;
        bit a0, a1;

        // reset values
        tick(); tick(); #1;
        chk("rst_out", {req0_ready, req1_ready, res0_valid, res1_valid, busy}, 5'b0);
        chk("rst_p", {res0_p, res1_p}, 32'h0);
        rst_n = 1;

        // single op and extremes
        do_op(0, 8'hFD, 8'h05, 16'hFFF1, "t1");
        do_op(0, 8'h7F, 8'h80, 16'hC080, "ext_7f80");
        do_op(1, 8'h80, 8'h80, 16'h4000, "ext_8080");
        do_op(0, 8'h00, 8'h80, 16'h0000, "ext_0080");

        // contention from reset
        do_reset();
        res0_ready = 1; res1_ready = 1;
        req0_valid = 1; req0_x = 8'd3;  req0_y = 8'd4;
        req1_valid = 1; req1_x = 8'hFE; req1_y = 8'd5;
        for (int n = 0; n < 40 && g.size() < 4; n++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) g.push_back(0);
            if (req1_valid && req1_ready) g.push_back(1);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        for (int i = 0; i < 4; i++) chk("grant_seq", (i < g.size()) ? g[i] : 9, exp_g[i]);
        tick(); tick(); tick();
        chk("cont_p0", res0_p, 16'h000C);
        chk("cont_p1", res1_p, 16'hFFF6);

        // backpressure on requester 1
        res1_ready = 0;
        req1_valid = 1; req1_x = 8'h0B; req1_y = 8'hF9;
        begin
            bit ok = 0;
            for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = req1_ready; end
            chk("bp_accept", ok, 1);
        end
        tick();
        req1_valid = 0;
        tick();
        held = res1_p;
        chk("bp_p", held, 16'hFFB3);
        req0_valid = 1; req0_x = 8'd3; req0_y = 8'd7;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {res1_valid, res0_valid, req0_ready, req1_ready, busy}, 5'b10001);
            chk("bp_stable", res1_p, held);
            tick();
        end
        res1_ready = 1;
        tick();
        chk("bp_release", {res1_valid, busy, req0_ready}, 3'b001);
        do_op(0, 8'd3, 8'd7, 16'h0015, "bp_next");

        // reset during CALC
        req0_valid = 1; req0_x = 8'h12; req0_y = 8'h34;
        begin
            bit ok = 0;
            for (int n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = req0_ready; end
            chk("mid_accept", ok, 1);
        end
        tick();
        req0_valid = 0;
        chk("mid_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("mid_async", {busy, res0_valid, res1_valid}, 3'b000);
        chk("mid_async_p", {res0_p, res1_p}, 32'h0);
        tick();
        rst_n = 1;
        tick(); tick();
        chk("mid_no_stale", {res0_valid, res1_valid, busy}, 3'b000);
        do_op(0, 8'hFD, 8'h05, 16'hFFF1, "mid_t1");

        // randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            tick();
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_x = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 8'($urandom);
                req0_y = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 8'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_x = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 8'($urandom);
                req1_y = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 4)] : 8'($urandom);
            end
            res0_ready = ($urandom_range(0, 3) != 0);
            res1_ready = ($urandom_range(0, 3) != 0);
        end

        req0_valid = 0; req1_valid = 0;
        res0_ready = 1; res1_ready = 1;
        repeat (5) tick();
        chk("drain_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
